// File: rtl/universal_shift_register.sv
// 74194-style universal shift register with shift counter and frame_done pulse.
// Optional XOR-of-q parity output enabled by defining USR_PARITY_EN.
module universal_shift_register #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             sr_in,
    input  logic             sl_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    shift_count,
    output logic             frame_done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             shifting;
    logic             last;

    assign op   = mode_t'(mode);
    assign last = (shift_count == CW'(WIDTH - 1));

    always_comb begin
        q_nxt    = q;
        cnt_nxt  = shift_count;
        done_nxt = 1'b0;
        shifting = 1'b0;
        if (clear) begin
            q_nxt   = '0;
            cnt_nxt = '0;
        end else begin
            unique case (op)
                MODE_HOLD: ;
                MODE_SHR: begin
                    q_nxt    = {sr_in, q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                MODE_SHL: begin
                    q_nxt    = {q[WIDTH-2:0], sl_in};
                    shifting = 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt   = d;
                    cnt_nxt = '0;
                end
                default: ;
            endcase
            // Both shift directions advance the same frame counter.
            if (shifting) begin
                if (last) begin
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = shift_count + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        q           <= q_nxt;
        shift_count <= cnt_nxt;
        frame_done  <= done_nxt;
    end

`ifdef USR_PARITY_EN
    assign parity = ^q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=4): directed vector
// table, hand sequences and random stimulus against an arithmetic model.
module tb_universal_shift_register;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    logic          clk;
    logic          clear;
    logic [1:0]    mode;
    logic          sr_in;
    logic          sl_in;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic [CW-1:0] shift_count;
    logic          frame_done;
`ifdef USR_PARITY_EN
    logic          parity;
`endif

    universal_shift_register #(.WIDTH(W)) dut (
        .clk         (clk),
        .clear       (clear),
        .mode        (mode),
        .sr_in       (sr_in),
        .sl_in       (sl_in),
        .d           (d),
        .q           (q),
        .shift_count (shift_count),
        .frame_done  (frame_done)
`ifdef USR_PARITY_EN
        ,
        .parity      (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic [1:0] mode;
        logic       sr;
        logic       sl;
        logic [3:0] d;
        logic [3:0] eq;
        int         ecnt;
        logic       edone;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: word value and shifts taken in the current frame
    int unsigned mq;
    int          mcnt;
    bit          mdone;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic c, input logic [1:0] m, input logic s_r, input logic s_l,
                        input logic [3:0] dd, input logic [3:0] eq, input int ec, input logic ed);
        vec_t v;
        v.clr = c; v.mode = m; v.sr = s_r; v.sl = s_l; v.d = dd;
        v.eq = eq; v.ecnt = ec; v.edone = ed;
        vecs.push_back(v);
    endtask

    task automatic drive_edge(input logic c, input logic [1:0] m, input logic s_r,
                              input logic s_l, input logic [W-1:0] dd);
        clear = c; mode = m; sr_in = s_r; sl_in = s_l; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic c, input logic [1:0] m, input logic s_r,
                              input logic s_l, input logic [W-1:0] dd);
        int unsigned mask;
        mask = (1 << W) - 1;
        mdone = 0;
        if (c) begin
            mq = 0; mcnt = 0;
        end else if (m == 2'd3) begin
            mq = dd; mcnt = 0;
        end else if (m != 2'd0) begin
            if (m == 2'd1) mq = (mq >> 1) | (int'(s_r) << (W - 1));
            else           mq = ((mq << 1) | int'(s_l)) & mask;
            mcnt++;
            if (mcnt == W) begin
                mcnt  = 0;
                mdone = 1;
            end
        end
    endtask

    task automatic apply(input string tag, input logic c, input logic [1:0] m,
                         input logic s_r, input logic s_l, input logic [W-1:0] dd);
        drive_edge(c, m, s_r, s_l, dd);
        model_step(c, m, s_r, s_l, dd);
        chk({tag, ".q"}, int'(q), int'(mq));
        chk({tag, ".shift_count"}, int'(shift_count), mcnt);
        chk({tag, ".frame_done"}, int'(frame_done), int'(mdone));
`ifdef USR_PARITY_EN
        chk({tag, ".parity"}, int'(parity), int'($countones(mq) % 2));
`endif
    endtask

    initial begin
        clear = 1'b0; mode = 2'b00; sr_in = 1'b0; sl_in = 1'b0; d = '0;
        mq = 0; mcnt = 0; mdone = 0;

        // reset with load request pending: clear wins
        addv(1, 2'b11, 0, 0, 4'hF, 4'h0, 0, 0);
        // load and hold
        addv(0, 2'b11, 0, 0, 4'hA, 4'hA, 0, 0);
        addv(0, 2'b00, 0, 0, 4'h0, 4'hA, 0, 0);
        addv(0, 2'b00, 0, 0, 4'h0, 4'hA, 0, 0);
        addv(0, 2'b00, 0, 0, 4'h0, 4'hA, 0, 0);
        // shift right framing, sr_in 1,0,1,1
        addv(0, 2'b11, 0, 0, 4'h0, 4'h0, 0, 0);
        addv(0, 2'b01, 1, 0, 4'h0, 4'h8, 1, 0);
        addv(0, 2'b01, 0, 0, 4'h0, 4'h4, 2, 0);
        addv(0, 2'b01, 1, 0, 4'h0, 4'hA, 3, 0);
        addv(0, 2'b01, 1, 0, 4'h0, 4'hD, 0, 1);
        addv(0, 2'b00, 0, 0, 4'h0, 4'hD, 0, 0);
        // continuous shift left, 8 edges
        addv(0, 2'b11, 0, 0, 4'h0, 4'h0, 0, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'h1, 1, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'h3, 2, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'h7, 3, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'hF, 0, 1);
        addv(0, 2'b10, 0, 1, 4'h0, 4'hF, 1, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'hF, 2, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'hF, 3, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'hF, 0, 1);
        // load right after frame_done
        addv(0, 2'b11, 0, 0, 4'h5, 4'h5, 0, 0);
        // mixed directions share one frame
        addv(0, 2'b01, 0, 0, 4'h0, 4'h2, 1, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'h5, 2, 0);
        addv(0, 2'b01, 1, 0, 4'h0, 4'hA, 3, 0);
        addv(0, 2'b10, 0, 0, 4'h0, 4'h4, 0, 1);
        // clear mid-frame (with shift requested), then full frame
        addv(0, 2'b01, 1, 0, 4'h0, 4'hA, 1, 0);
        addv(0, 2'b01, 0, 0, 4'h0, 4'h5, 2, 0);
        addv(1, 2'b01, 1, 0, 4'h0, 4'h0, 0, 0);
        addv(0, 2'b01, 1, 0, 4'h0, 4'h8, 1, 0);
        addv(0, 2'b01, 1, 0, 4'h0, 4'hC, 2, 0);
        addv(0, 2'b01, 1, 0, 4'h0, 4'hE, 3, 0);
        addv(0, 2'b01, 1, 0, 4'h0, 4'hF, 0, 1);
        // load mid-frame, then full frame
        addv(0, 2'b01, 0, 0, 4'h0, 4'h7, 1, 0);
        addv(0, 2'b01, 0, 0, 4'h0, 4'h3, 2, 0);
        addv(0, 2'b11, 0, 0, 4'h0, 4'h0, 0, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'h1, 1, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'h3, 2, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'h7, 3, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'hF, 0, 1);
        // parity pattern: 0111 then 1111
        addv(0, 2'b11, 0, 0, 4'h7, 4'h7, 0, 0);
        addv(0, 2'b10, 0, 1, 4'h0, 4'hF, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_edge(vecs[i].clr, vecs[i].mode, vecs[i].sr, vecs[i].sl, vecs[i].d);
            chk($sformatf("vec%0d.q", i), int'(q), int'(vecs[i].eq));
            chk($sformatf("vec%0d.shift_count", i), int'(shift_count), vecs[i].ecnt);
            chk($sformatf("vec%0d.frame_done", i), int'(frame_done), int'(vecs[i].edone));
`ifdef USR_PARITY_EN
            chk($sformatf("vec%0d.parity", i), int'(parity), int'(^vecs[i].eq));
`endif
        end

        // hold mid-frame keeps the count; frame completes on the 4th shift
        apply("hs_clr", 1, 2'b00, 0, 0, 4'h0);
        apply("hs_s1", 0, 2'b01, 1, 0, 4'h0);
        apply("hs_s2", 0, 2'b10, 0, 1, 4'h0);
        apply("hs_s3", 0, 2'b01, 0, 0, 4'h0);
        apply("hs_h1", 0, 2'b00, 1, 1, 4'hF);
        apply("hs_h2", 0, 2'b00, 0, 0, 4'h3);
        apply("hs_s4", 0, 2'b10, 0, 1, 4'h0);
        apply("hs_h3", 0, 2'b00, 0, 0, 4'h0);

        for (int i = 0; i < 400; i++) begin
            logic          c;
            logic [1:0]    m;
            logic [W-1:0]  dd;
            c  = ($urandom_range(0, 19) == 0);
            m  = 2'($urandom_range(0, 3));
            dd = W'($urandom);
            apply($sformatf("rnd%0d", i), c, m, 1'($urandom), 1'($urandom), dd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parameterised universal shift register (74194 style) built as the next stage after the team's D flip-flop cell.
- Holds, shifts right, shifts left or parallel-loads a WIDTH-bit word.
- Counts shift operations and pulses frame_done once WIDTH shifts have completed, so a serial stream can be framed into parallel words.
- Sits downstream of single-bit storage and feeds parallel consumers such as displays or comparators.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.
- CW, $clog2(WIDTH), width of the shift counter; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clear  input  1  synchronous active-high reset.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_in  input  1  serial input for shift right; enters the MSB.
- sl_in  input  1  serial input for shift left; enters the LSB.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- shift_count  output  CW  shifts completed in the current frame.
- frame_done  output  1  one-cycle pulse at the end of each frame.
- parity  output  1  XOR of q; present only with the optional feature (see below).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named clear.
- Reset: clear=1 at a rising edge sets q=0, shift_count=0 and frame_done=0. clear has priority over every mode.
- Register q, registered, 1-cycle latency:
  - mode 00: q unchanged, shift_count unchanged.
  - mode 01: q <= {sr_in, q[WIDTH-1:1]}; q[0] is discarded.
  - mode 10: q <= {q[WIDTH-2:0], sl_in}; q[WIDTH-1] is discarded.
  - mode 11: q <= d; shift_count <= 0. The load starts a new frame.
- Counter (modes 01 and 10):
  - If shift_count < WIDTH-1: increment shift_count.
  - If shift_count == WIDTH-1: wrap shift_count to 0 and set frame_done=1 on the same edge. This is the WIDTH-th shift of the frame.
- frame_done:
  - Registered; high for exactly one cycle after the completing edge.
  - Cleared on any edge that does not complete a frame, including hold, load and clear.
- Direction changes: mixing left and right shifts within a frame is legal; both directions count toward the same frame.
- Back-to-back frames: continuous shifting gives a frame_done pulse every WIDTH cycles with no gap cycle.
- Hold: freezes both q and shift_count. frame_done drops after its single cycle.
- Reset mid-frame: discards the partial count; the next frame needs a full WIDTH shifts.
- Load on the cycle after frame_done: legal; frame_done still deasserts normally.
- Flip-flop model: all flip-flops are plain storage with no asynchronous preset or clear. Synchronous clear is folded into the next-state logic.
- No combinational path from any input to q, shift_count or frame_done.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined:
  - parity = XOR reduction of q, combinational from the registered q only.
  - parity=0 after reset.
  - parity updates the same cycle q changes.
- Undefined: the parity port does not exist and there is no parity logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with WIDTH=4: drive mode=11, d=4'hF, clear=1 for one edge -> q=0, shift_count=0, frame_done=0; with the feature, parity=0.
- Load and hold: mode=11, d=4'b1010 for one edge, then mode=00 for 3 edges -> q=4'b1010 throughout, shift_count=0, frame_done never asserted.
- Shift right framing: after load 0, mode=01 with sr_in sequence 1,0,1,1 -> q ends 4'b1101, shift_count goes 1,2,3,0, frame_done high only after the 4th edge.
- Shift left, continuous: load 0, then mode=10 with sl_in=1 for 8 edges -> q=4'b1111 after edge 4 and stays; frame_done pulses after edges 4 and 8 only.
- Mid-frame interruption: 2 right shifts, then clear=1 for one edge, then 4 shifts -> no frame_done until the 4th post-clear shift. Repeat with a load (mode=11) in place of clear -> same result.
- Parity (feature on): load 4'b0111 -> parity=1; shift left with sl_in=1 -> q=4'b1111, parity=0.
